// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage load/store unit (master) and the memory (slave).
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM stage: issues aligned loads/stores on the data bus, stalls until ready or timeout,
// formats load data and drives the MEM/WB register.
module mem_stage_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   regwriteM,
    input  logic                   memwriteM,
    input  logic [2:0]             resultsrcM,
    input  logic [2:0]             loadsrcM,
    input  logic [4:0]             rdM,
    input  logic [31:0]            aluresultM,
    input  logic [31:0]            writeDataM,
    input  logic [31:0]            auipcM,
    input  logic [31:0]            immextM,
    input  logic [31:0]            pcplus4M,
    output logic                   stallM,
    mem_stage_lsu_if.master        dmem,
    output logic                   regwriteW,
    output logic                   validW,
    output logic [4:0]             rdW,
    output logic [31:0]            resultW,
    output logic                   misalign_err,
    output logic                   bus_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        regwrite_q, regwrite_d, valid_q, valid_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] result_q, result_d;
    logic        mis_q, mis_d, buserr_q, buserr_d;
    logic        stall_c;

    logic [1:0]  lane;
    logic        mem_op, is_half, is_word, misaligned;
    logic [31:0] load_data, wb_value;
    logic [35:0] store_fmt;

    function automatic logic [31:0] load_extract(input logic [2:0] code, input logic [1:0] ln,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{ln, 3'b000} +: 8];
        h = ln[1] ? word[31:16] : word[15:0];
        case (code)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return word;
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return 32'b0;
        endcase
    endfunction

    // Upper 4 bits are the byte enables, lower 32 the lane-replicated store data.
    function automatic logic [35:0] store_format(input logic [2:0] code, input logic [1:0] ln,
                                                 input logic [31:0] data);
        case (code)
            3'b000:  return {4'b0001 << ln, {4{data[7:0]}}};
            3'b001:  return {(ln[1] ? 4'b1100 : 4'b0011), {2{data[15:0]}}};
            default: return {4'b1111, data};
        endcase
    endfunction

    function automatic logic [31:0] wb_select(input logic [2:0] sel, input logic [31:0] alu,
                                              input logic [31:0] ld, input logic [31:0] pc4,
                                              input logic [31:0] imm, input logic [31:0] auipc);
        case (sel)
            3'b000:  return alu;
            3'b001:  return ld;
            3'b010:  return pc4;
            3'b011:  return imm;
            3'b100:  return auipc;
            default: return 32'b0;
        endcase
    endfunction

    assign lane       = aluresultM[1:0];
    assign mem_op     = memwriteM | (resultsrcM == 3'b001);
    assign is_half    = (loadsrcM[1:0] == 2'b01);
    assign is_word    = (loadsrcM[1:0] == 2'b10);
    assign misaligned = (is_half & lane[0]) | (is_word & (lane != 2'b00));
    assign load_data  = load_extract(loadsrcM, lane, dmem.dmem_rdata);
    assign store_fmt  = store_format(loadsrcM, lane, writeDataM);
    assign wb_value   = wb_select(resultsrcM, aluresultM, load_data, pcplus4M, immextM, auipcM);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        regwrite_d = 1'b0;
        valid_d    = 1'b0;
        rd_d       = 5'd0;
        result_d   = 32'd0;
        mis_d      = 1'b0;
        buserr_d   = 1'b0;
        stall_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op && misaligned) begin
                    mis_d = 1'b1;
                end else if (mem_op) begin
                    req_d   = 1'b1;
                    we_d    = memwriteM;
                    addr_d  = {aluresultM[31:2], 2'b00};
                    be_d    = memwriteM ? store_fmt[35:32] : 4'b1111;
                    wdata_d = memwriteM ? store_fmt[31:0] : 32'd0;
                    cnt_d   = 8'd0;
                    state_d = ACCESS;
                    stall_c = 1'b1;
                end else begin
                    regwrite_d = regwriteM;
                    valid_d    = 1'b1;
                    rd_d       = rdM;
                    result_d   = wb_value;
                end
            end
            ACCESS: begin
                // A ready arriving on the last allowed cycle still completes normally.
                if (dmem.dmem_ready) begin
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    cnt_d      = 8'd0;
                    state_d    = IDLE;
                    regwrite_d = memwriteM ? 1'b0 : regwriteM;
                    valid_d    = 1'b1;
                    rd_d       = rdM;
                    result_d   = wb_value;
                end else if (cnt_q == CNT_LAST) begin
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    cnt_d    = 8'd0;
                    state_d  = IDLE;
                    buserr_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    stall_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            regwrite_q <= 1'b0;
            valid_q    <= 1'b0;
            rd_q       <= 5'd0;
            result_q   <= 32'd0;
            mis_q      <= 1'b0;
            buserr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            regwrite_q <= regwrite_d;
            valid_q    <= valid_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
            mis_q      <= mis_d;
            buserr_q   <= buserr_d;
        end
    end

    assign stallM          = rst ? stall_c : 1'b0;
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;
    assign regwriteW       = regwrite_q;
    assign validW          = valid_q;
    assign rdW             = rd_q;
    assign resultW         = result_q;
    assign misalign_err    = mis_q;
    assign bus_err         = buserr_q;

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameter TIMEOUT, 255, maximum number of ACCESS cycles to wait for dmem_ready before aborting (1..255).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 regwriteM, memwriteM  input  1 each  control fields from the EX/MEM register.
REQ-005 resultsrcM, loadsrcM  input  3 each  result select and access size/sign code.
REQ-006 rdM  input  5  destination register.
REQ-007 aluresultM, writeDataM, auipcM, immextM, pcplus4M  input  32 each  EX/MEM data fields; aluresultM is the effective address.
REQ-008 stallM  output  1  holds the EX/MEM register and all upstream stages.
REQ-009 dmem_req, dmem_we  output  1 each  memory request and write enable (registered).
REQ-010 dmem_addr, dmem_wdata  output  32 each  word-aligned address and lane-shifted store data (registered).
REQ-011 dmem_be  output  4  byte enables (registered).
REQ-012 dmem_ready  input  1  memory completes the current request this cycle.
REQ-013 dmem_rdata  input  32  read word, valid when dmem_ready is high.
REQ-014 regwriteW, validW  output  1 each  MEM/WB register controls.
REQ-015 rdW  output  5; resultW  output  32  MEM/WB destination and final writeback value.
REQ-016 misalign_err, bus_err  output  1 each  one-cycle error pulses (registered).

Function
REQ-017 Memory op = memwriteM, or resultsrcM == 3'b001 (load).
REQ-018 loadsrcM codes: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned; stores use 000/001/010 only.
REQ-019 Misaligned = half with addr[0]=1, or word with addr[1:0]!=0; misaligned ops issue no bus request.
REQ-020 States: IDLE, ACCESS.
REQ-021 IDLE, aligned memory op: load dmem_* registers, dmem_req=1, next state ACCESS, stallM=1 this cycle.
REQ-022 IDLE, misaligned memory op: misalign_err=1 next cycle, MEM/WB receives a bubble, stallM=0, stay IDLE.
REQ-023 IDLE, non-memory op: stallM=0, MEM/WB captures the result next edge (1-cycle latency).
REQ-024 ACCESS: dmem_req and all dmem_* outputs hold stable until dmem_ready=1.
REQ-025 ACCESS with dmem_ready=0: stallM=1, timeout counter increments, MEM/WB receives a bubble.
REQ-026 ACCESS with dmem_ready=1: stallM=0, dmem_req drops next edge, MEM/WB captures the access result, state goes to IDLE, counter clears.
REQ-027 Counter reaching TIMEOUT in ACCESS without ready: bus_err=1 next cycle, abort to IDLE, MEM/WB bubble, dmem_req=0, stallM=0.
REQ-028 dmem_addr = {aluresultM[31:2],2'b00}; byte lane = aluresultM[1:0].
REQ-029 Stores: byte be=1<<lane, wdata=byte replicated x4; half be=0011/1100, wdata=half replicated x2; word be=1111.
REQ-030 Loads: dmem_we=0, be=1111; lane-selected byte/half sign- or zero-extended per loadsrcM.
REQ-031 resultW select: 000 aluresultM, 001 load data, 010 pcplus4M, 011 immextM, 100 auipcM, others 0.
REQ-032 Bubble = regwriteW=0, validW=0, rdW=0, resultW=0.
REQ-033 Stores capture regwriteW=0, validW=1 on completion.
REQ-034 dmem_ready in IDLE is ignored.
REQ-035 Timeout on the same cycle as dmem_ready: ready wins, normal completion.

Reset
REQ-036 rst=0 at a rising edge: state IDLE, counter 0, all registered outputs 0 (dmem_*, MEM/WB fields, error pulses).
REQ-037 Reset mid-ACCESS aborts without completion or error pulse; stallM=0 while rst=0.

Verification
REQ-038 ALU op, resultsrcM=000, aluresultM=0x1234, rdM=5, regwriteM=1 -> next cycle resultW=0x1234, rdW=5, regwriteW=1, stallM never high.
REQ-039 LB at addr 0x103, ready 2 cycles after req, rdata=0x80xxxxxx -> stallM high 3 cycles, dmem_addr=0x100, resultW=0xFFFFFF80; LBU gives 0x00000080.
REQ-040 SH at 0x202, writeDataM=0xABCD1234 -> dmem_be=1100, dmem_wdata=0x12341234, dmem_we=1, regwriteW=0, validW=1.
REQ-041 LW at 0x105 -> no dmem_req, misalign_err pulse 1 cycle, bubble, stallM low.
REQ-042 TIMEOUT=4, dmem_ready held 0 -> bus_err pulse, dmem_req low, state IDLE, bubble; ready and timeout together -> normal completion.
REQ-043 rst=0 during ACCESS -> all outputs 0 next edge, no writeback, no error pulse.
